// File: rtl/add_pipe_pkg.sv
// Shared types and helpers for the pipelined add/sub unit: slice width, flag
// bit positions, the per-stage pipeline record and 4-bit lookahead equations.
package add_pipe_pkg;

  localparam int SLICE_W    = 16;
  localparam int MAX_NSLICE = 4;
  localparam int MAX_W      = SLICE_W * MAX_NSLICE;
  localparam int MAX_TAG_W  = 8;

  // out_flags layout is {N,Z,C,V}
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // Sized for the largest supported unit; narrower builds leave the upper bits idle.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [MAX_TAG_W-1:0] tag;
    logic [MAX_W-1:0]     a_rem;
    logic [MAX_W-1:0]     b_rem;
    logic [MAX_W-1:0]     sum_done;
  } stage_rec_t;

  // Carries into bits 0..3 of a 4-bit group, all flattened to two logic levels.
  function automatic logic [3:0] cla4_carry(input logic [2:0] g, input logic [2:0] p,
                                            input logic cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  function automatic logic cla4_group_gen(input logic [3:0] g, input logic [3:1] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/add16_slice.sv
// Combinational 16-bit two-level carry-lookahead adder: four 4-bit groups whose
// group generate/propagate terms feed a second lookahead level.
module add16_slice
  import add_pipe_pkg::*;
(
  input  logic               i_cin,
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  output logic [SLICE_W-1:0] o_s,
  output logic               o_cout
);

  localparam int NGRP = SLICE_W / 4;

  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_c;
  logic [NGRP-1:0]    w_grp_g;
  logic [NGRP-1:0]    w_grp_p;
  logic [NGRP-1:0]    w_grp_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  generate
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
      assign w_grp_g[gi]      = cla4_group_gen(w_g[4*gi +: 4], w_p[4*gi+1 +: 3]);
      assign w_grp_p[gi]      = &w_p[4*gi +: 4];
      assign w_c[4*gi +: 4]   = cla4_carry(w_g[4*gi +: 3], w_p[4*gi +: 3], w_grp_c[gi]);
    end
  endgenerate

  assign w_grp_c = cla4_carry(w_grp_g[2:0], w_grp_p[2:0], i_cin);
  assign o_cout  = cla4_group_gen(w_grp_g, w_grp_p[3:1]) | (&w_grp_p & i_cin);
  assign o_s     = w_p ^ w_c;

endmodule

// File: rtl/add_pipe_stage.sv
// Pipelined add/sub execute unit: one 16-bit CLA slice per stage, carry registered
// between stages. Define ADD_PIPE_FLAGS_EN to produce {N,Z,C,V}; otherwise flags read 0.
module add_pipe_stage
  import add_pipe_pkg::*;
#(
  parameter int NSLICE = 2,
  parameter int TAG_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLICE_W*NSLICE-1:0] in_a,
  input  logic [SLICE_W*NSLICE-1:0] in_b,
  input  logic                      in_sub,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SLICE_W*NSLICE-1:0] out_sum,
  output logic [TAG_W-1:0]          out_tag,
  output logic [3:0]                out_flags
);

  localparam int WIDTH = SLICE_W * NSLICE;
  localparam int LAST  = NSLICE - 1;

  stage_rec_t         r_stage [NSLICE];
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_sum;
  logic [TAG_W-1:0]   r_out_tag;
  logic [3:0]         r_out_flags;

  logic [SLICE_W-1:0] w_slice_s    [NSLICE];
  logic               w_slice_cout [NSLICE];
  logic               w_adv;
  logic [WIDTH-1:0]   w_final_sum;
  logic               w_flag_n;
  logic               w_flag_z;
  logic               w_flag_c;
  logic               w_flag_v;
  logic [3:0]         w_flags;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv && !flush;

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      add16_slice u_slice (
        .i_cin  (r_stage[gi].carry),
        .i_a    (r_stage[gi].a_rem[gi*SLICE_W +: SLICE_W]),
        .i_b    (r_stage[gi].b_rem[gi*SLICE_W +: SLICE_W]),
        .o_s    (w_slice_s[gi]),
        .o_cout (w_slice_cout[gi])
      );
    end
  endgenerate

  always_comb begin
    w_final_sum = r_stage[LAST].sum_done[WIDTH-1:0];
    w_final_sum[LAST*SLICE_W +: SLICE_W] = w_slice_s[LAST];
  end

`ifdef ADD_PIPE_FLAGS_EN
  // b_rem already holds the inverted operand for subtracts, so one V rule covers both.
  assign w_flag_n = w_final_sum[WIDTH-1];
  assign w_flag_z = (w_final_sum == '0);
  assign w_flag_c = w_slice_cout[LAST];
  assign w_flag_v = (r_stage[LAST].a_rem[WIDTH-1] == r_stage[LAST].b_rem[WIDTH-1]) &&
                    (w_final_sum[WIDTH-1] != r_stage[LAST].a_rem[WIDTH-1]);
`else
  assign w_flag_n = 1'b0;
  assign w_flag_z = 1'b0;
  assign w_flag_c = 1'b0;
  assign w_flag_v = 1'b0;
`endif

  always_comb begin
    w_flags         = 4'b0000;
    w_flags[FLAG_N] = w_flag_n;
    w_flags[FLAG_Z] = w_flag_z;
    w_flags[FLAG_C] = w_flag_c;
    w_flags[FLAG_V] = w_flag_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSLICE; k++) begin
        r_stage[k].valid <= 1'b0;
      end
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_tag   <= '0;
      r_out_flags <= 4'b0000;
    end else begin
      if (w_adv) begin
        r_stage[0].valid    <= in_valid && !flush;
        r_stage[0].carry    <= in_sub;
        r_stage[0].tag      <= MAX_TAG_W'(in_tag);
        r_stage[0].a_rem    <= MAX_W'(in_a);
        r_stage[0].b_rem    <= MAX_W'(in_b ^ {WIDTH{in_sub}});
        r_stage[0].sum_done <= '0;
        for (int k = 1; k < NSLICE; k++) begin
          r_stage[k]       <= r_stage[k-1];
          r_stage[k].carry <= w_slice_cout[k-1];
          r_stage[k].sum_done[(k-1)*SLICE_W +: SLICE_W] <= w_slice_s[k-1];
        end
        r_out_valid <= r_stage[LAST].valid;
        // Bubbles leave the visible result registers untouched.
        if (r_stage[LAST].valid) begin
          r_out_sum   <= w_final_sum;
          r_out_tag   <= r_stage[LAST].tag[TAG_W-1:0];
          r_out_flags <= w_flags;
        end
      end
      if (flush) begin
        for (int k = 0; k < NSLICE; k++) begin
          r_stage[k].valid <= 1'b0;
        end
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_tag   = r_out_tag;
  assign out_flags = r_out_flags;

endmodule
